altr_hps_ckgate_ctrl: RTL

ALTR_HPS_CKGATE_CTRL -- requirements
Module: altr_hps_ckgate_ctrl

---
 rtl/altr_hps_ckgate_pkg.sv | 26 ++
 rtl/altr_hps_ckgate_cnt.sv | 41 ++++
 rtl/altr_hps_ckgate_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/altr_hps_ckgate_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : altr_hps_ckgate_pkg
//  Description : Shared definitions for the HPS clock-gate controller.
//                Provides the FSM state encoding (OFF/WAKE/ON/IDLE), the
//                default wake-up hold length and the width of the wake
//                counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package altr_hps_ckgate_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_IDLE = 2'd3
    } ckg_state_e;

    // Default number of cycles clk_en is held before the first grant.
    localparam int c_wake_cyc_dflt = 2;

    // Wake hold length is at most 15 cycles, so 4 bits cover WAKE_CYC-1.
    localparam int c_wake_w = 4;

endpackage : altr_hps_ckgate_pkg
`default_nettype wire

// File: rtl/altr_hps_ckgate_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : altr_hps_ckgate_cnt
//  Description : Loadable down-counter with zero flag. Holds at zero rather
//                than wrapping, so a decrement request at zero is harmless.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                i_load        - load i_load_val (has priority over i_dec)
//                i_load_val    - value to load
//                i_dec         - decrement by one when non-zero
//                o_zero        - count register equals zero
//  Revision    : 1.0 - initial release
// ============================================================================
module altr_hps_ckgate_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;
    logic             w_zero;

    assign w_zero = (r_count == '0);
    assign o_zero = w_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && !w_zero) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule : altr_hps_ckgate_cnt
`default_nettype wire

// File: rtl/altr_hps_ckgate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : altr_hps_ckgate_ctrl
//  Description : Clock-gate enable controller. Requesters raise req[i]; the
//                controller enables the downstream clock, waits WAKE_CYC
//                cycles for it to settle, then grants ack[i]. When demand
//                disappears the clock stays on for idle_limit+1 cycles
//                before gating off. force_on keeps the clock running
//                without producing grants.
//  Ports       : clk         - free-running source clock
//                rst         - asynchronous active-high reset
//                req         - per-requester clock request (level)
//                force_on    - software override, clock kept on, no ack
//                idle_limit  - idle cycles tolerated before gating off
//                clk_en      - registered enable for the external AND cell
//                ack         - per-requester grant (clock running while high)
//                state       - current FSM state (OFF/WAKE/ON/IDLE)
//  Revision    : 1.0 - initial release
// ============================================================================
module altr_hps_ckgate_ctrl
    import altr_hps_ckgate_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int CNT_W    = 8,
    parameter int WAKE_CYC = c_wake_cyc_dflt
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               force_on,
    input  logic [CNT_W-1:0]   idle_limit,
    output logic               clk_en,
    output logic [NUM_REQ-1:0] ack,
    output logic [1:0]         state
);

    localparam logic [c_wake_w-1:0] c_wake_load = c_wake_w'(WAKE_CYC - 1);

    ckg_state_e         r_state;
    ckg_state_e         w_next_state;
    logic               r_clk_en;
    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] w_ack_next;

    logic w_demand;
    logic w_wake_load;
    logic w_wake_dec;
    logic w_wake_zero;
    logic w_idle_load;
    logic w_idle_dec;
    logic w_idle_zero;

    assign w_demand = (|req) | force_on;

    // Wake-up hold counter.
    altr_hps_ckgate_cnt #(
        .WIDTH (c_wake_w)
    ) u_wake_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_wake_load),
        .i_load_val (c_wake_load),
        .i_dec      (w_wake_dec),
        .o_zero     (w_wake_zero)
    );

    // Idle timeout counter; idle_limit is captured only on entry to IDLE.
    altr_hps_ckgate_cnt #(
        .WIDTH (CNT_W)
    ) u_idle_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_idle_load),
        .i_load_val (idle_limit),
        .i_dec      (w_idle_dec),
        .o_zero     (w_idle_zero)
    );

    always_comb begin
        w_next_state = r_state;
        w_wake_load  = 1'b0;
        w_wake_dec   = 1'b0;
        w_idle_load  = 1'b0;
        w_idle_dec   = 1'b0;
        w_ack_next   = '0;
        case (r_state)
            ST_OFF: begin
                if (w_demand) begin
                    w_next_state = ST_WAKE;
                    w_wake_load  = 1'b1;
                end
            end
            ST_WAKE: begin
                // Proceeds to ON even if demand vanished during wake-up.
                if (w_wake_zero) begin
                    w_next_state = ST_ON;
                end else begin
                    w_wake_dec = 1'b1;
                end
            end
            ST_ON: begin
                // Grants track requests one edge late; acks only ever come
                // from ON, so IDLE/OFF/WAKE see ack cleared.
                w_ack_next = req;
                if (!w_demand) begin
                    w_next_state = ST_IDLE;
                    w_idle_load  = 1'b1;
                end
            end
            ST_IDLE: begin
                if (w_demand) begin
                    w_next_state = ST_ON;
                end else if (w_idle_zero) begin
                    w_next_state = ST_OFF;
                end else begin
                    w_idle_dec = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_OFF;
            r_clk_en <= 1'b0;
            r_ack    <= '0;
        end else begin
            r_state  <= w_next_state;
            // Enable drops on the same edge the FSM enters OFF.
            r_clk_en <= (w_next_state != ST_OFF);
            r_ack    <= w_ack_next;
        end
    end

    assign clk_en = r_clk_en;
    assign ack    = r_ack;
    assign state  = r_state;

endmodule : altr_hps_ckgate_ctrl
`default_nettype wire
